// File: rtl/mult_controller.sv
// Sequencing FSM for the normalising approximate multiplier datapath.
// Walks 8 operand pairs: load, normalise, multiply, denormalise, store.
module mult_controller #(
    parameter int GUARD_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic Co3,
    input  logic DoneA,
    input  logic DoneB,
    input  logic down_done,
    output logic read,
    output logic write,
    output logic rst3,
    output logic cnt3,
    output logic SA,
    output logic SB,
    output logic loadA,
    output logic ShlA,
    output logic loadB,
    output logic ShlB,
    output logic rst5,
    output logic cntU,
    output logic cntD,
    output logic loadOut,
    output logic ShrOut,
    output logic busy,
    output logic done
);

    // state     | meaning
    // IDLE      | waiting for start, all strobes low
    // INIT      | clear pair counter and shift counter
    // LOAD_A    | read even RAM word into A, clear guard
    // LOAD_B    | read odd RAM word into B
    // SHIFT_A   | shift A left until MSB set or guard expires
    // SHIFT_B   | shift B left until MSB set or guard expires
    // MULT      | capture product into result register
    // SHIFT_OUT | shift result right once per counted normalising shift
    // WRITE     | store result to output RAM
    // NEXT      | advance pair counter, clear shift counter
    // FINISH    | one-cycle done pulse
    typedef enum logic [3:0] {
        IDLE,
        INIT,
        LOAD_A,
        LOAD_B,
        SHIFT_A,
        SHIFT_B,
        MULT,
        SHIFT_OUT,
        WRITE,
        NEXT,
        FINISH
    } state_t;

    localparam logic [3:0] GUARD_LIM = 4'(GUARD_MAX);

    state_t     state, state_nxt;
    logic [3:0] guard, guard_nxt;
    logic       guard_hit;

    // >= rather than == so a guard value can never run past the limit
    assign guard_hit = (guard >= GUARD_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            guard <= 4'd0;
        end else begin
            state <= state_nxt;
            guard <= guard_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        guard_nxt = guard;
        read      = 1'b0;
        write     = 1'b0;
        rst3      = 1'b0;
        cnt3      = 1'b0;
        SA        = 1'b0;
        SB        = 1'b0;
        loadA     = 1'b0;
        ShlA      = 1'b0;
        loadB     = 1'b0;
        ShlB      = 1'b0;
        rst5      = 1'b0;
        cntU      = 1'b0;
        cntD      = 1'b0;
        loadOut   = 1'b0;
        ShrOut    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                rst3      = 1'b1;
                rst5      = 1'b1;
                state_nxt = LOAD_A;
            end
            LOAD_A: begin
                read      = 1'b1;
                SA        = 1'b1;
                loadA     = 1'b1;
                guard_nxt = 4'd0;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                read      = 1'b1;
                SB        = 1'b1;
                loadB     = 1'b1;
                state_nxt = SHIFT_A;
            end
            SHIFT_A: begin
                if (!DoneA && !guard_hit) begin
                    ShlA      = 1'b1;
                    cntU      = 1'b1;
                    guard_nxt = guard + 4'd1;
                end else begin
                    guard_nxt = 4'd0;
                    state_nxt = SHIFT_B;
                end
            end
            SHIFT_B: begin
                if (!DoneB && !guard_hit) begin
                    ShlB      = 1'b1;
                    cntU      = 1'b1;
                    guard_nxt = guard + 4'd1;
                end else begin
                    guard_nxt = 4'd0;
                    state_nxt = MULT;
                end
            end
            MULT: begin
                loadOut   = 1'b1;
                state_nxt = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                if (!down_done) begin
                    ShrOut = 1'b1;
                    cntD   = 1'b1;
                end else begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                write     = 1'b1;
                state_nxt = NEXT;
            end
            NEXT: begin
                cnt3      = 1'b1;
                rst5      = 1'b1;
                state_nxt = Co3 ? FINISH : LOAD_A;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                guard_nxt = 4'd0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: behavioural datapath around the FSM, with
// per-pair products, shift counts and batch latency predicted from the operands.
module tb_mult_controller;

    logic clk = 1'b0;
    logic rst, start, force_co3;
    logic Co3, DoneA, DoneB, down_done;
    logic read, write, rst3, cnt3, SA, SB, loadA, ShlA, loadB, ShlB;
    logic rst5, cntU, cntD, loadOut, ShrOut, busy, done;

    always #5 clk = ~clk;

    mult_controller #(.GUARD_MAX(15)) dut (
        .clk(clk), .rst(rst), .start(start), .Co3(Co3), .DoneA(DoneA),
        .DoneB(DoneB), .down_done(down_done), .read(read), .write(write),
        .rst3(rst3), .cnt3(cnt3), .SA(SA), .SB(SB), .loadA(loadA),
        .ShlA(ShlA), .loadB(loadB), .ShlB(ShlB), .rst5(rst5), .cntU(cntU),
        .cntD(cntD), .loadOut(loadOut), .ShrOut(ShrOut), .busy(busy),
        .done(done)
    );

    logic [16:0] outs;
    assign outs = {read, write, rst3, cnt3, SA, SB, loadA, ShlA, loadB, ShlB,
                   rst5, cntU, cntD, loadOut, ShrOut, busy, done};

    // datapath model
    logic [15:0] in_ram [16];
    logic [15:0] reg_a, reg_b;
    logic [31:0] reg_p;
    logic [4:0]  sc;
    logic [2:0]  pc;

    assign Co3       = (pc == 3'd7) || force_co3;
    assign DoneA     = reg_a[15];
    assign DoneB     = reg_b[15];
    assign down_done = (sc == 5'd0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0; sc <= '0; reg_a <= '0; reg_b <= '0; reg_p <= '0;
        end else begin
            if (rst3) pc <= '0;
            else if (cnt3) pc <= pc + 3'd1;
            if (rst5) sc <= '0;
            else if (cntU) sc <= sc + 5'd1;
            else if (cntD) sc <= sc - 5'd1;
            if (loadA) reg_a <= in_ram[{pc, 1'b0}];
            else if (ShlA) reg_a <= reg_a << 1;
            if (loadB) reg_b <= in_ram[{pc, 1'b1}];
            else if (ShlB) reg_b <= reg_b << 1;
            if (loadOut) reg_p <= 32'(reg_a) * 32'(reg_b);
            else if (ShrOut) reg_p <= reg_p >> 1;
        end
    end

    // strobe monitor
    int n_cnt3 = 0, n_sel_err = 0;
    int cur_shla = 0, cur_shlb = 0, cur_shr = 0, cur_cu = 0, cur_cd = 0;
    logic [31:0] wq_prod[$];
    int wq_idx[$], wq_shla[$], wq_shlb[$], wq_shr[$], wq_cu[$], wq_cd[$];

    always @(negedge clk) begin
        if (rst) begin
            if (rst3) begin
                cur_shla = 0; cur_shlb = 0; cur_shr = 0; cur_cu = 0; cur_cd = 0;
            end
            if (ShlA) cur_shla++;
            if (ShlB) cur_shlb++;
            if (ShrOut) cur_shr++;
            if (cntU) cur_cu++;
            if (cntD) cur_cd++;
            if (cnt3) n_cnt3++;
            if ((loadA && !(SA && read)) || (loadB && !(SB && read))) n_sel_err++;
            if (write) begin
                wq_prod.push_back(reg_p);
                wq_idx.push_back(int'(pc));
                wq_shla.push_back(cur_shla);
                wq_shlb.push_back(cur_shlb);
                wq_shr.push_back(cur_shr);
                wq_cu.push_back(cur_cu);
                wq_cd.push_back(cur_cd);
                cur_shla = 0; cur_shlb = 0; cur_shr = 0; cur_cu = 0; cur_cd = 0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // normalising shifts for an operand: leading zeros, capped by the guard
    function automatic int lz(input logic [15:0] v);
        int n = 0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return (n > 15) ? 15 : n;
    endfunction

    function automatic logic [15:0] gen_op();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) return 16'h0000;
        r = ($urandom | 32'h8000) & 32'hFFFF;
        return 16'(r >> $urandom_range(0, 15));
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 16; i++) in_ram[i] = gen_op();
    endtask

    task automatic wait_done(input bit keep, input int poke, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (i == 0 && !keep) start = 1'b0;
            if (poke > 0 && i == poke) start = 1'b1;
            if (poke > 0 && i == poke + 1) start = 1'b0;
            if (busy) n++;
            if (done) ok = 1'b1;
        end
    endtask

    task automatic run_batch(input string tag, input bit keep, input int poke, input int npairs);
        int exp_lat, n, base, c3base, sa, sb, k;
        bit ok;
        exp_lat = 2;
        for (int p = 0; p < npairs; p++)
            exp_lat += 8 + 2 * (lz(in_ram[2*p]) + lz(in_ram[2*p+1]));
        base   = wq_prod.size();
        c3base = n_cnt3;
        @(negedge clk);
        start = 1'b1;
        wait_done(keep, poke, n, ok);
        chk({tag, "_done_seen"}, ok, 1);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_writes"}, wq_prod.size() - base, npairs);
        chk({tag, "_cnt3"}, n_cnt3 - c3base, npairs);
        for (int p = 0; p < npairs; p++) begin
            k = base + p;
            if (k < wq_prod.size()) begin
                sa = lz(in_ram[2*p]);
                sb = lz(in_ram[2*p+1]);
                chk({tag, "_prod"}, wq_prod[k], 32'(in_ram[2*p]) * 32'(in_ram[2*p+1]));
                chk({tag, "_pair_idx"}, wq_idx[k], p);
                chk({tag, "_shla"}, wq_shla[k], sa);
                chk({tag, "_shlb"}, wq_shlb[k], sb);
                chk({tag, "_shr"}, wq_shr[k], sa + sb);
                chk({tag, "_cntu"}, wq_cu[k], sa + sb);
                chk({tag, "_cntd"}, wq_cd[k], sa + sb);
            end
        end
    endtask

    initial begin
        int n, wbase;
        bit ok;
        rst = 1'b0;
        start = 1'b0;
        force_co3 = 1'b0;
        for (int i = 0; i < 16; i++) in_ram[i] = 16'h8000;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, 17'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs, 17'd0);

        // already-normalised operands: no shifting, 66-cycle batch
        run_batch("norm", 1'b0, 0, 8);
        @(negedge clk);
        chk("norm_done_pulse", done, 0);
        chk("norm_busy_fall", busy, 0);

        // mixed shifts, zero operands, start poked while busy
        fill_random();
        in_ram[0] = 16'h0100; in_ram[1] = 16'h0800;
        in_ram[2] = 16'h0000; in_ram[5] = 16'h0000;
        in_ram[6] = 16'h0000; in_ram[7] = 16'h0000;
        run_batch("mixed", 1'b0, 10, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("poke_ignored", busy, 0);
        end

        // start held high: back-to-back batches with one idle cycle
        fill_random();
        run_batch("held1", 1'b1, 0, 8);
        @(negedge clk);
        chk("held_idle_gap", busy, 0);
        @(negedge clk);
        chk("held_restart", busy, 1);
        chk("held_init", rst3, 1);
        start = 1'b0;
        wait_done(1'b1, 0, n, ok);
        chk("held2_done_seen", ok, 1);
        begin
            int exp_lat = 2;
            for (int p = 0; p < 8; p++)
                exp_lat += 8 + 2 * (lz(in_ram[2*p]) + lz(in_ram[2*p+1]));
            chk("held2_latency", n + 1, exp_lat);
        end

        // early carry ends the batch after one pair
        fill_random();
        force_co3 = 1'b1;
        run_batch("co3", 1'b0, 0, 1);
        @(negedge clk);
        chk("co3_done_pulse", done, 0);
        chk("co3_busy_fall", busy, 0);
        force_co3 = 1'b0;

        // asynchronous reset in the middle of SHIFT_OUT
        fill_random();
        in_ram[0] = 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && !ShrOut; i++) @(negedge clk);
        chk("rst_reach_shr", ShrOut, 1);
        wbase = wq_prod.size();
        #2 rst = 1'b0;
        #1 chk("rst_async_outs", outs, 17'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_idle_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("rst_no_write", wq_prod.size() - wbase, 0);
        run_batch("after_rst", 1'b0, 0, 8);

        chk("ram_select", n_sel_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_controller.md
# mult_controller

Control FSM for the normalising 8×8 approximate multiplier datapath. It drives the datapath's RAM, counter and shift-register strobes, and consumes its status flags (Co3, DoneA, DoneB, down_done). For each of 8 operand pairs in input RAM it loads A and B, normalises each until its MSB is 1 while counting shifts, loads the product and right-shifts it back by the total shift count, then writes it to output RAM.

## Interface
Parameters:
- GUARD_MAX, default 15: maximum left shifts per operand before normalisation is forced to end (zero-operand guard).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low; forces state IDLE.
- start  input  1  begin a batch of 8 pairs; sampled in IDLE only.
- Co3  input  1  pair counter is at 7 (combinational carry from datapath).
- DoneA  input  1  A register MSB = 1.
- DoneB  input  1  B register MSB = 1.
- down_done  input  1  5-bit shift counter = 0.
- read  output  1  input RAM read enable.
- write  output  1  output RAM write enable.
- rst3  output  1  synchronous clear of pair counter.
- cnt3  output  1  increment pair counter.
- SA  output  1  select even RAM word (operand A).
- SB  output  1  select odd RAM word (operand B).
- loadA, ShlA  output  1  load / shift-left A register.
- loadB, ShlB  output  1  load / shift-left B register.
- rst5  output  1  synchronous clear of 5-bit shift counter.
- cntU, cntD  output  1  shift counter up / down.
- loadOut, ShrOut  output  1  load / shift-right result register.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at batch completion.

## Operation
- States: IDLE, INIT, LOAD_A, LOAD_B, SHIFT_A, SHIFT_B, MULT, SHIFT_OUT, WRITE, NEXT, FINISH.
- IDLE: all outputs 0. start=1 → INIT; otherwise stay.
- INIT: rst3=1, rst5=1 → LOAD_A.
- LOAD_A: read=1, SA=1, loadA=1; clear guard → LOAD_B.
- LOAD_B: read=1, SB=1, loadB=1 → SHIFT_A.
- SHIFT_A: if DoneA=0 and guard<GUARD_MAX, then ShlA=1, cntU=1, guard+1, stay. If DoneA=1 or guard=GUARD_MAX, clear guard → SHIFT_B; no strobes that cycle.
- SHIFT_B: same as SHIFT_A using DoneB/ShlB → MULT.
- MULT: loadOut=1 → SHIFT_OUT.
- SHIFT_OUT: if down_done=0, then ShrOut=1, cntD=1, stay; else → WRITE.
- WRITE: write=1 → NEXT.
- NEXT: cnt3=1, rst5=1. If Co3=1 → FINISH (counter wraps to 0); else → LOAD_A.
- FINISH: done=1 → IDLE.
- Outputs are combinational from state, DoneA/DoneB, down_done and guard. No output depends on start.
- The guard is an internal 4-bit register. Only the two SHIFT states use it.
- Shift counter never exceeds 2×GUARD_MAX = 30, which fits in 5 bits.

## Timing
- State register updates on the rising clk edge. rst low clears state and guard to IDLE/0 immediately, without waiting for a clock edge.
- Reset value of every output is 0, including busy and done.
- Reset mid-batch aborts the batch. No further write is issued, and the next start restarts from pair 0.
- start while busy=1 is ignored. start held high through FINISH launches a new batch from the IDLE cycle that follows.
- Latency per pair = 8 + sA + sB + (sA+sB) cycles, where sA and sB are the left-shift counts.
- Batch latency = 1 (INIT) + Σ per-pair latency + 1 (FINISH), measured from the first busy cycle to the done cycle inclusive.
- write is high for exactly one cycle per pair. cnt3 pulses 8 times per batch.
- Zero operand: exactly GUARD_MAX shifts, then the FSM proceeds and the product is 0.

## Test plan
- Reset: assert rst=0 mid-SHIFT_OUT → all outputs 0 asynchronously; after release, state is IDLE and busy=0.
- All pairs 0x8000×0x8000, start pulse → no ShlA/ShlB/ShrOut; done exactly 66 cycles after start is sampled; 8 write pulses.
- Pair 0x0100×0x0800 → ShlA for 7 cycles, ShlB for 4 cycles, ShrOut for 11 cycles; cntU count = cntD count = 11.
- A=0x0000 → exactly 15 ShlA cycles, then SHIFT_B entered; write still occurs for that pair.
- start asserted during busy → no effect; start held continuously → back-to-back batches with exactly one IDLE cycle between done and the next INIT.
- Co3 forced high on the first pair → FINISH after one pair; done pulses one cycle; busy falls the cycle after.
